instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Generates the instruction stream consumed by the decode stage: holds the PC, issues
//  word fetches to instruction memory over a req/gnt/rvalid interface, buffers returned
//  words with their PC, and presents them to decode with a valid/ready handshake.
//  Sits in stage 1 of the 3-stage core, ahead of the main decoder. Accepts redirects
//  from branch/jal/jalr resolution.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address after reset
//  FIFO_DEPTH  2              instruction buffer entries; also caps fetches in flight (>=2, power of 2)
// PORTS
//  clk            in   1   core clock, all state on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  redirect_i     in   1   flush and restart fetch at redirect_pc_i
//  redirect_pc_i  in   32  redirect target; bits [1:0] ignored (forced 0)
//  imem_req_o     out  1   fetch request
//  imem_addr_o    out  32  fetch address (word aligned)
//  imem_gnt_i     in   1   request accepted this cycle (ignored when imem_req_o=0)
//  imem_rvalid_i  in   1   read data valid, responses in request order
//  imem_rdata_i   in   32  instruction word
//  if_valid_o     out  1   if_instr_o/if_pc_o valid to decode
//  if_instr_o     out  32  instruction; 32'h0000_0013 (NOP) when if_valid_o=0
//  if_pc_o        out  32  PC of if_instr_o
//  if_ready_i     in   1   decode accepts; transfer on if_valid_o & if_ready_i
// BEHAVIOUR
//  Reset: pc_q=RESET_PC, state=IDLE, inflight=0, drop_cnt=0, FIFO empty; imem_req_o=0,
//   imem_addr_o=RESET_PC, if_valid_o=0, if_instr_o=NOP, if_pc_o=0. Takes effect immediately.
//  FSM: IDLE -> RUN on first clock after rst_n release (no request in IDLE).
//   RUN -> DRAIN on redirect_i when responses remain outstanding after this cycle; else stays RUN.
//   DRAIN -> RUN on the cycle drop_cnt reaches 0. redirect_i in DRAIN: reload pc_q, stay DRAIN.
//  Credit: imem_req_o = (state==RUN) & ~redirect_i & (inflight + fifo_count < FIFO_DEPTH).
//   imem_addr_o = pc_q. On req&gnt: pc_q <= pc_q+4 (mod 2^32, 0xFFFF_FFFC wraps to 0),
//   inflight++, pc_q pushed to pending-PC queue.
//  Response: rvalid with drop_cnt==0 pushes {pending PC, rdata} into FIFO, inflight--.
//   Credit scheme guarantees no overflow; push while full is an assertion failure.
//   rvalid with inflight==0 ignored, assertion failure.
//  Output: if_valid_o = FIFO non-empty (registered, FWFT). Data held stable while
//   if_valid_o & ~if_ready_i. Min latency gnt->if_valid_o: rvalid cycle + 1.
//  Redirect (highest priority): pc_q <= {redirect_pc_i[31:2],2'b00}; FIFO and pending-PC
//   queue flushed; drop_cnt <= inflight - (rvalid this cycle); no request this cycle;
//   if_valid_o=0 next cycle. A pop in the same cycle as redirect is still a valid transfer.
//  DRAIN: each rvalid decrements drop_cnt and inflight, data discarded; no requests.
//  Simultaneous push+pop: both occur, count unchanged. gnt+rvalid same cycle: inflight unchanged.
//  Reset mid-burst: all in-flight state lost; imem is reset on the same rst_n.
// STRUCTURE
//  riscv_pkg: XLEN=32, INSTR_NOP=32'h0000_0013, typedef enum logic[1:0] {FETCH_IDLE,
//   FETCH_RUN, FETCH_DRAIN} fetch_state_t.
//  Sub-module fetch_fifo: sync FIFO, params WIDTH/DEPTH, push/pop/flush, full/empty/count;
//   instantiated twice (64-bit {pc,instr} buffer, 32-bit pending-PC queue).
// TESTING
//  1 Release reset, gnt=1, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000 -> imem_addr
//    0,4,8..; if_pc_o 0,4,8 with matching rdata; first if_valid_o 3 cycles after release.
//  2 if_ready_i=0 from start -> exactly 2 grants then imem_req_o=0; if_pc_o=0 held stable;
//    raise if_ready_i -> requests resume at addr 8, no instruction lost or duplicated.
//  3 Two fetches in flight, redirect_i with redirect_pc_i=32'h0000_0103 -> state DRAIN,
//    both responses discarded, next request addr 32'h0000_0100, next if_pc_o=32'h100.
//  4 Redirect coincident with rvalid, one in flight -> that response dropped, drop_cnt=0,
//    stays RUN, request to target issued next cycle.
//  5 Redirect to 32'hFFFF_FFF8, free-run -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6 Assert rst_n=0 mid-burst between edges -> imem_req_o, if_valid_o fall immediately,
//    if_instr_o=NOP; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core constants and the fetch-stage state type.
package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_RUN,
      FETCH_DRAIN
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous first-word-fall-through FIFO with flush; read data is the
// registered head entry, so it stays stable until popped.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rptr_q];

   // pointers and occupancy; flush discards everything, including a same-cycle push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // storage array, no reset needed: entries are only read while counted valid
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr_q] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Stage-1 fetch: PC, credit-limited imem requests, in-order response buffering
// and a valid/ready hand-off to decode. Redirects flush and drop stale responses.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_instr_o,
   output logic [XLEN-1:0] if_pc_o,
   input  logic            if_ready_i
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_t      state_q, state_d;
   logic [XLEN-1:0]   pc_q;
   logic [CW-1:0]     inflight_q, inflight_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
   logic [CW:0]       credit_used;
   logic              fire, rv_ok, rsp_keep;

   logic [2*XLEN-1:0] ibuf_rdata;
   logic              ibuf_full, ibuf_empty;
   logic [CW-1:0]     ibuf_count;
   logic [XLEN-1:0]   pend_pc;
   logic              pend_full, pend_empty;
   logic [CW-1:0]     pend_count;

   assign credit_used = {1'b0, inflight_q} + {1'b0, ibuf_count};
   assign fire        = imem_req_o & imem_gnt_i;
   assign rv_ok       = imem_rvalid_i & (inflight_q != '0);
   // a response is kept only outside drain and when no redirect kills it this cycle
   assign rsp_keep    = rv_ok & (drop_cnt_q == '0) & ~redirect_i;

   // next-state, request credit and in-flight/drop bookkeeping
   always_comb begin
      state_d    = state_q;
      imem_req_o = 1'b0;
      inflight_d = inflight_q + CW'(fire) - CW'(rv_ok);
      drop_cnt_d = drop_cnt_q;
      if (redirect_i)
         drop_cnt_d = inflight_q - CW'(rv_ok);
      else if (rv_ok && drop_cnt_q != '0)
         drop_cnt_d = drop_cnt_q - CW'(1);
      case (state_q)
         FETCH_IDLE: state_d = FETCH_RUN;
         FETCH_RUN: begin
            imem_req_o = ~redirect_i & (credit_used < (CW+1)'(FIFO_DEPTH));
            if (redirect_i && drop_cnt_d != '0) state_d = FETCH_DRAIN;
         end
         FETCH_DRAIN: if (drop_cnt_d == '0) state_d = FETCH_RUN;
         default: state_d = FETCH_IDLE;
      endcase
   end

   // state, PC and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH_IDLE;
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         if (redirect_i) pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
         else if (fire)  pc_q <= pc_q + XLEN'(4);
      end
   end

   // instruction buffer: {pc, instr}, head is what decode sees
   fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_ibuf (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_i),
      .push  (rsp_keep),
      .wdata ({pend_pc, imem_rdata_i}),
      .pop   (if_ready_i),
      .rdata (ibuf_rdata),
      .full  (ibuf_full),
      .empty (ibuf_empty),
      .count (ibuf_count)
   );

   // PCs of granted requests awaiting their response
   fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pend (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_i),
      .push  (fire),
      .wdata (pc_q),
      .pop   (rv_ok & (drop_cnt_q == '0)),
      .rdata (pend_pc),
      .full  (pend_full),
      .empty (pend_empty),
      .count (pend_count)
   );

   assign imem_addr_o = pc_q;
   assign if_valid_o  = ~ibuf_empty;
   assign if_instr_o  = if_valid_o ? ibuf_rdata[XLEN-1:0] : INSTR_NOP;
   assign if_pc_o     = if_valid_o ? ibuf_rdata[2*XLEN-1:XLEN] : '0;

   a_rv_orphan: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rvalid_i |-> inflight_q != '0);
   a_ibuf_ovf:  assert property (@(posedge clk) disable iff (!rst_n)
      rsp_keep |-> !ibuf_full);
   a_pend_ovf:  assert property (@(posedge clk) disable iff (!rst_n)
      fire |-> !pend_full);
   a_pend_head: assert property (@(posedge clk) disable iff (!rst_n)
      (imem_rvalid_i && drop_cnt_q == '0) |-> !pend_empty);
   a_pend_sync: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == FETCH_RUN) |-> pend_count == inflight_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit: an in-order imem model with random
// grant/latency, random decode back-pressure and redirects, checked every cycle
// against a queue-level model of outstanding requests and buffered instructions.
module tb_instr_fetch_unit;
   import riscv_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
   logic [31:0] imem_addr_o, imem_rdata_i = '0;
   logic        if_valid_o, if_ready_i = 1'b0;
   logic [31:0] if_instr_o, if_pc_o;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
      .if_ready_i(if_ready_i));

   typedef struct {
      logic [31:0] addr;
      bit          drop;
      int          rdy;
   } req_t;

   req_t        out_q[$];          // granted, response not yet returned
   logic [31:0] buf_q[$];          // PCs whose instruction waits for decode
   logic [31:0] gnt_log[$], pop_log[$];
   logic [31:0] mpc;
   bit          started;
   int          n_chk = 0, n_fail = 0, cyc = 0, rel_cyc = 0, first_valid = -1;
   int          p_gnt, p_rv, p_rdy, p_redir, lat_max;
   bit          force_redir = 0;
   logic [31:0] force_pc = '0;

   function automatic logic [31:0] word_of(logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] qat(logic [31:0] q[$], int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // one clock: drive at negedge, check #1 later, advance the model at posedge
   task automatic step();
      bit          redir, rv, pend, exp_req, exp_vld, g, pop;
      logic [31:0] rpc;
      redir = force_redir || ($urandom_range(0, 99) < p_redir);
      rpc   = force_redir ? force_pc : $urandom();
      rv    = (out_q.size() > 0) && (out_q[0].rdy <= cyc) && ($urandom_range(0, 99) < p_rv);
      redirect_i    = redir;
      redirect_pc_i = rpc;
      imem_gnt_i    = ($urandom_range(0, 99) < p_gnt);
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? word_of(out_q[0].addr) : $urandom();
      if_ready_i    = ($urandom_range(0, 99) < p_rdy);
      #1;
      pend = 0;
      foreach (out_q[i]) if (out_q[i].drop) pend = 1;
      exp_req = started && !pend && !redir && (out_q.size() + buf_q.size() < DEPTH);
      exp_vld = buf_q.size() > 0;
      chk("imem_req", imem_req_o, exp_req);
      chk("imem_addr", imem_addr_o, mpc);
      chk("if_valid", if_valid_o, exp_vld);
      if (exp_vld) begin
         chk("if_pc", if_pc_o, buf_q[0]);
         chk("if_instr", if_instr_o, word_of(buf_q[0]));
      end else begin
         chk("if_instr_nop", if_instr_o, INSTR_NOP);
      end
      if (if_valid_o && first_valid < 0) first_valid = rel_cyc;
      g   = exp_req && imem_gnt_i;
      pop = exp_vld && if_ready_i;
      @(posedge clk);
      cyc++;
      rel_cyc++;
      if (pop) begin
         pop_log.push_back(buf_q[0]);
         void'(buf_q.pop_front());
      end
      if (rv) begin
         req_t h;
         h = out_q.pop_front();
         if (!h.drop && !redir) buf_q.push_back(h.addr);
      end
      if (redir) begin
         buf_q.delete();
         foreach (out_q[i]) out_q[i].drop = 1;
         mpc = {rpc[31:2], 2'b00};
      end else if (g) begin
         out_q.push_back('{mpc, 1'b0, cyc + $urandom_range(0, lat_max)});
         gnt_log.push_back(mpc);
         mpc = mpc + 32'd4;
      end
      started = 1;
      @(negedge clk);
   endtask

   task automatic set_knobs(int g, int rv, int rdy, int rd, int lat);
      p_gnt = g; p_rv = rv; p_rdy = rdy; p_redir = rd; lat_max = lat;
   endtask

   // hold reset (imem state is lost with it), check reset outputs, release at a negedge
   task automatic do_reset();
      rst_n = 1'b0;
      redirect_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; if_ready_i = 0;
      out_q.delete(); buf_q.delete(); gnt_log.delete(); pop_log.delete();
      mpc = RPC; started = 0;
      repeat (2) @(negedge clk);
      chk("rst_req", imem_req_o, 1'b0);
      chk("rst_addr", imem_addr_o, RPC);
      chk("rst_valid", if_valid_o, 1'b0);
      chk("rst_instr", if_instr_o, INSTR_NOP);
      chk("rst_pc", if_pc_o, 32'h0);
      rst_n = 1'b1;
      rel_cyc = 0;
      first_valid = -1;
   endtask

   initial begin
      // 1: free-running stream from reset
      set_knobs(100, 100, 100, 0, 0);
      do_reset();
      repeat (8) step();
      chk("t1_first_valid", first_valid, 3);
      chk("t1_gnt0", qat(gnt_log, 0), 32'h0);
      chk("t1_gnt1", qat(gnt_log, 1), 32'h4);
      chk("t1_gnt2", qat(gnt_log, 2), 32'h8);
      chk("t1_pop0", qat(pop_log, 0), 32'h0);
      chk("t1_pop2", qat(pop_log, 2), 32'h8);

      // 2: decode stalled from the start
      set_knobs(100, 100, 0, 0, 0);
      do_reset();
      repeat (8) step();
      chk("t2_grants", gnt_log.size(), 2);
      chk("t2_req_low", imem_req_o, 1'b0);
      chk("t2_held_pc", if_pc_o, 32'h0);
      chk("t2_held_vld", if_valid_o, 1'b1);
      p_rdy = 100;
      repeat (10) step();
      chk("t2_resume", qat(gnt_log, 2), 32'h8);
      chk("t2_pop1", qat(pop_log, 1), 32'h4);
      chk("t2_pop3", qat(pop_log, 3), 32'hC);

      // 3: redirect with two fetches in flight
      set_knobs(100, 0, 100, 0, 0);
      do_reset();
      repeat (4) step();
      chk("t3_inflight", out_q.size(), 2);
      force_redir = 1; force_pc = 32'h0000_0103;
      step();
      force_redir = 0;
      chk("t3_drain", 32'(dut.state_q), 32'(FETCH_DRAIN));
      gnt_log.delete(); pop_log.delete();
      p_rv = 100;
      repeat (8) step();
      chk("t3_req", qat(gnt_log, 0), 32'h100);
      chk("t3_pc", qat(pop_log, 0), 32'h100);

      // 4: redirect coincident with the only response
      set_knobs(100, 0, 100, 0, 0);
      do_reset();
      repeat (2) step();
      p_gnt = 0; p_rv = 100;
      force_redir = 1; force_pc = 32'h0000_0200;
      step();
      force_redir = 0;
      chk("t4_drop", 32'(dut.drop_cnt_q), 32'h0);
      chk("t4_run", 32'(dut.state_q), 32'(FETCH_RUN));
      p_gnt = 100; gnt_log.delete();
      step();
      chk("t4_req", qat(gnt_log, 0), 32'h200);

      // 5: address wrap
      set_knobs(100, 100, 100, 0, 0);
      force_redir = 1; force_pc = 32'hFFFF_FFF8;
      step();
      force_redir = 0;
      gnt_log.delete();
      repeat (6) step();
      chk("t5_a0", qat(gnt_log, 0), 32'hFFFF_FFF8);
      chk("t5_a1", qat(gnt_log, 1), 32'hFFFF_FFFC);
      chk("t5_a2", qat(gnt_log, 2), 32'h0000_0000);

      // 6: asynchronous reset between edges
      set_knobs(100, 100, 100, 0, 0);
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_req", imem_req_o, 1'b0);
      chk("t6_valid", if_valid_o, 1'b0);
      chk("t6_instr", if_instr_o, INSTR_NOP);
      @(negedge clk);
      do_reset();
      repeat (4) step();
      chk("t6_restart", qat(gnt_log, 0), RPC);

      // random traffic
      for (int r = 0; r < 6; r++) begin
         set_knobs($urandom_range(30, 100), $urandom_range(30, 100),
                   $urandom_range(20, 100), $urandom_range(0, 8), $urandom_range(0, 3));
         repeat (1500) step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
